// File: rtl/rf_dump_load.sv
// rf_dump_load: bulk dump/load sequencer for the 32x32 register file.
// Ports: start/mode/first/count command, busy/done status, in_* load
// stream, out_* dump stream, rf_rr1/rf_rd1 read port, rf_wr/rf_wd/rf_w
// write port (driven only while loading).
module rf_dump_load #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] first,
    input  logic [5:0]    count,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] rf_rr1,
    input  logic [DW-1:0] rf_rd1,
    output logic [AW-1:0] rf_wr,
    output logic [DW-1:0] rf_wd,
    output logic          rf_w
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [5:0]    rem_q, rem_d;
    logic [DW-1:0] odata_q, odata_d;
    logic          ovalid_q, ovalid_d;
    logic          busy_q, done_q;
    logic          out_ld;

    // The output register may take a new word when empty or being drained.
    assign out_ld = (state_q == S_DUMP) && (!ovalid_q || out_ready);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d = first;
                    rem_d = count;
                    if (count == 6'd0)
                        state_d = S_FIN;
                    else if (mode)
                        state_d = S_LOAD;
                    else
                        state_d = S_DUMP;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ptr_d = ptr_q + AW'(1);
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1)
                        state_d = S_FIN;
                end
            end
            S_DUMP: begin
                if (out_ld) begin
                    odata_d  = rf_rd1;
                    ovalid_d = 1'b1;
                    ptr_d    = ptr_q + AW'(1);
                    rem_d    = rem_q - 6'd1;
                    if (rem_q == 6'd1)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ovalid_q && out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = S_FIN;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up
    // exactly with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_FIN);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = odata_q;
    assign out_valid = ovalid_q;
    assign in_ready  = (state_q == S_LOAD);
    assign rf_w      = (state_q == S_LOAD) && in_valid;
    assign rf_wr     = (state_q == S_LOAD) ? ptr_q : '0;
    assign rf_wd     = (state_q == S_LOAD) ? in_data : '0;
    assign rf_rr1    = (state_q == S_DUMP) ? ptr_q : '0;

endmodule

// File: tb/tb_rf_dump_load.sv
// tb_rf_dump_load: directed bench for rf_dump_load with a register-file
// harness and a scoreboard monitor for write and dump streams.
module tb_rf_dump_load;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode;
    logic [4:0]  first;
    logic [5:0]  count;
    logic        busy, done;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready;
    logic [4:0]  rf_rr1, rf_wr;
    logic [31:0] rf_rd1, rf_wd;
    logic        rf_w;

    rf_dump_load #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .first(first), .count(count), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rf_rr1(rf_rr1), .rf_rd1(rf_rd1),
        .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_w(rf_w)
    );

    // Register file harness: combinational read, write on posedge.
    logic [31:0] regs [32];
    logic        rf_clr;
    assign rf_rd1 = regs[rf_rr1];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (rf_w) begin
            regs[rf_wr] <= rf_wd;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [31:0] exp_out [$];
    logic [36:0] exp_wr  [$];

    int          done_cnt = 0;
    int          ov_cnt   = 0;
    logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
    logic [31:0] pd = '0;
    logic [4:0]  prr = '0;
    logic [36:0] ew;
    logic [31:0] eo;

    // Monitor: pops expectations on each write and each accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid) ov_cnt++;
            if (!prst && pv && !pr) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(pd));
                chk("hold_rr1", 64'(rf_rr1), 64'(prr));
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", 64'(exp_out.size() != 0), 64'd1);
                if (exp_out.size() != 0) begin
                    eo = exp_out.pop_front();
                    chk("beat_data", 64'(out_data), 64'(eo));
                end
            end
            if (rf_w) begin
                chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    ew = exp_wr.pop_front();
                    chk("wr_idx", 64'(rf_wr), 64'(ew[36:32]));
                    chk("wr_data", 64'(rf_wd), 64'(ew[31:0]));
                end
            end
        end
        pv   = out_valid;
        pr   = out_ready;
        pd   = out_data;
        prr  = rf_rr1;
        prst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic [4:0] f,
                         input logic [5:0] c);
        mode  = m;
        first = f;
        count = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          d0, ov0;
    logic [3:0]  pat;

    initial begin
        rst = 1'b1; rf_clr = 1'b1; start = 1'b0; mode = 1'b0;
        first = '0; count = '0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b0;
        step(); step();
        rf_clr = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_rf_w", 64'(rf_w), 64'd0);
        chk("rst_rf_wr", 64'(rf_wr), 64'd0);
        chk("rst_rf_rr1", 64'(rf_rr1), 64'd0);
        rst = 1'b0;
        step();

        // Load 3 registers with wrap 30,31,0.
        exp_wr.push_back({5'd30, 32'hA});
        exp_wr.push_back({5'd31, 32'hB});
        exp_wr.push_back({5'd0, 32'hC});
        d0 = done_cnt;
        in_valid = 1'b1; in_data = 32'hA;
        issue(1'b1, 5'd30, 6'd3);
        chk("ld_in_ready", 64'(in_ready), 64'd1);
        chk("ld_busy", 64'(busy), 64'd1);
        step(); in_data = 32'hB;
        step(); in_data = 32'hC;
        step(); in_valid = 1'b0;
        chk("ld_done", 64'(done), 64'd1);
        chk("ld_fin_busy", 64'(busy), 64'd1);
        chk("ld_fin_ready", 64'(in_ready), 64'd0);
        step();
        chk("ld_done_end", 64'(done), 64'd0);
        chk("ld_idle", 64'(busy), 64'd0);
        chk("ld_r30", 64'(regs[30]), 64'hA);
        chk("ld_r31", 64'(regs[31]), 64'hB);
        chk("ld_r0", 64'(regs[0]), 64'hC);
        chk("ld_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Dump the same 3 registers, ready held high.
        exp_out.push_back(32'hA);
        exp_out.push_back(32'hB);
        exp_out.push_back(32'hC);
        out_ready = 1'b1;
        issue(1'b0, 5'd30, 6'd3);
        chk("dp_lat_ov0", 64'(out_valid), 64'd0);
        chk("dp_rr1", 64'(rf_rr1), 64'd30);
        step();
        chk("dp_first_v", 64'(out_valid), 64'd1);
        chk("dp_first_d", 64'(out_data), 64'hA);
        step();
        chk("dp_second_d", 64'(out_data), 64'hB);
        step();
        chk("dp_third_d", 64'(out_data), 64'hC);
        step();
        chk("dp_done", 64'(done), 64'd1);
        chk("dp_ov_clr", 64'(out_valid), 64'd0);
        step();
        chk("dp_idle", 64'(busy), 64'd0);

        // Load 4 registers at 5..8, then dump under backpressure.
        for (int k = 0; k < 4; k++)
            exp_wr.push_back({5'(5 + k), 32'((k + 1) << 8)});
        in_valid = 1'b1; in_data = 32'h100;
        issue(1'b1, 5'd5, 6'd4);
        for (int k = 1; k < 4; k++) begin
            step();
            in_data = 32'((k + 1) << 8);
        end
        step(); in_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++)
            exp_out.push_back(32'((k + 1) << 8));
        pat = 4'b1001;
        d0 = done_cnt;
        issue(1'b0, 5'd5, 6'd4);
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            out_ready = pat[i % 4];
            step();
        end
        chk("bp_done", 64'(done), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("bp_all_beats", 64'(exp_out.size()), 64'd0);

        // count = 0 in both modes, with live stream inputs.
        for (int m = 0; m < 2; m++) begin
            d0 = done_cnt; ov0 = ov_cnt;
            in_valid = 1'b1; in_data = 32'hDEAD;
            issue(m[0], 5'd7, 6'd0);
            chk("z_busy", 64'(busy), 64'd1);
            chk("z_done", 64'(done), 64'd1);
            chk("z_in_ready", 64'(in_ready), 64'd0);
            step();
            in_valid = 1'b0;
            chk("z_idle", 64'(busy), 64'd0);
            chk("z_done_end", 64'(done), 64'd0);
            step();
            chk("z_done_cnt", 64'(done_cnt - d0), 64'd1);
            chk("z_no_out", 64'(ov_cnt - ov0), 64'd0);
        end

        // Reset after 2 of 5 load handshakes.
        exp_wr.push_back({5'd10, 32'h51});
        exp_wr.push_back({5'd11, 32'h52});
        d0 = done_cnt;
        in_valid = 1'b1; in_data = 32'h51;
        issue(1'b1, 5'd10, 6'd5);
        step(); in_data = 32'h52;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rr_in_ready", 64'(in_ready), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_rf_w", 64'(rf_w), 64'd0);
        rst = 1'b0;
        step();
        chk("rr_r10", 64'(regs[10]), 64'h51);
        chk("rr_r11", 64'(regs[11]), 64'h52);
        chk("rr_r12", 64'(regs[12]), 64'h0);
        chk("rr_no_done", 64'(done_cnt - d0), 64'd0);
        exp_wr.push_back({5'd12, 32'h61});
        exp_wr.push_back({5'd13, 32'h62});
        in_valid = 1'b1; in_data = 32'h61;
        issue(1'b1, 5'd12, 6'd2);
        step(); in_data = 32'h62;
        step(); in_valid = 1'b0;
        chk("rr_reload_done", 64'(done), 64'd1);
        step();
        chk("rr_r12_new", 64'(regs[12]), 64'h61);
        chk("rr_r13_new", 64'(regs[13]), 64'h62);

        // start during a running dump is ignored.
        exp_out.push_back(32'h51);
        exp_out.push_back(32'h52);
        out_ready = 1'b1;
        d0 = done_cnt;
        issue(1'b0, 5'd10, 6'd2);
        mode = 1'b1; first = 5'd0; count = 6'd9; start = 1'b1;
        step();
        start = 1'b0;
        chk("ig_in_ready", 64'(in_ready), 64'd0);
        chk("ig_first_d", 64'(out_data), 64'h51);
        step();
        chk("ig_second_d", 64'(out_data), 64'h52);
        step();
        chk("ig_done", 64'(done), 64'd1);
        step();
        chk("ig_idle", 64'(busy), 64'd0);
        step(); step();
        chk("ig_stay_idle", 64'(busy), 64'd0);
        chk("ig_done_cnt", 64'(done_cnt - d0), 64'd1);

        step(); step();
        chk("end_out_q", 64'(exp_out.size()), 64'd0);
        chk("end_wr_q", 64'(exp_wr.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
